xrs_gen: RTL and testbench
==========================

XRS_GEN -- requirements
Module: xrs_gen

Interface
REQ-001 The block SHALL provide parameter XLEN, default 64, data width in bits.
REQ-002 The block SHALL provide parameter ADDRW, default 5, register address width; depth = 2**ADDRW.
REQ-003 The block SHALL provide parameter NRD, default 2, number of independent read ports (1..4).
REQ-004 The block SHALL provide parameter ZERO_R0, default 1, meaning register 0 is hardwired to zero.
REQ-005 The block SHALL provide parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL have port clk_i, input, 1 bit, the sole clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port rd_i, input, ADDRW bits, write address.
REQ-010 The block SHALL have port rdat_i, input, XLEN bits, write data.
REQ-011 The block SHALL have port rwe_i, input, 1 bit, write enable.
REQ-012 The block SHALL have port ra_i, input, NRD*ADDRW bits, read addresses; port k is at [k*ADDRW +: ADDRW].
REQ-013 The block SHALL have port rre_i, input, NRD bits, per-port read enable.
REQ-014 The block SHALL have port rdat_o, output, NRD*XLEN bits, read data; port k is at [k*XLEN +: XLEN].
REQ-015 The block SHALL have port ready_o, output, 1 bit, high when initialisation is complete and the block accepts accesses.

Function
REQ-016 Reads SHALL be synchronous with one-cycle latency: ra_i sampled at edge N with rre_i[k]=1 SHALL appear on rdat_o[k] after edge N.
REQ-017 When rre_i[k]=0 at an edge, rdat_o[k] SHALL hold its previous value.
REQ-018 With ZERO_R0=1, the zero substitution SHALL use the registered read address, not the live ra_i; a sampled address 0 SHALL read 0.
REQ-019 With ZERO_R0=1, writes to address 0 SHALL be discarded.
REQ-020 A write SHALL commit when rwe_i=1 and ready_o=1 at an edge; all NRD banks SHALL receive the identical write.
REQ-021 With BYPASS=1, if rwe_i=1 and rd_i equals the read address sampled by port k in the same edge (excluding address 0 when ZERO_R0=1), rdat_o[k] SHALL equal rdat_i; with BYPASS=0 it SHALL return the old contents.
REQ-022 The FSM SHALL have two states, CLEAR and RUN; reset SHALL enter CLEAR with clear counter 0.
REQ-023 In CLEAR, the block SHALL write zero to address = counter in every bank each cycle and increment the counter; user writes SHALL be ignored; rdat_o SHALL read 0.
REQ-024 When the counter equals 2**ADDRW-1 in CLEAR, the block SHALL transition to RUN on the next edge; clearing takes exactly 2**ADDRW cycles after reset release.
REQ-025 ready_o SHALL be 1 only in RUN.
REQ-026 Counter arithmetic SHALL be ADDRW bits, and no wrap past 2**ADDRW-1 SHALL occur.
REQ-027 Reads issued in CLEAR SHALL return 0 one cycle later and SHALL not stall.

Reset
REQ-028 Asserting rst_ni low SHALL immediately force state CLEAR, counter 0, ready_o 0, and all rdat_o to 0.
REQ-029 Reset asserted mid-CLEAR or mid-RUN SHALL restart clearing from address 0 after release; no partial write may commit while rst_ni is low.
REQ-030 Storage arrays SHALL carry no reset; their initial zero state is established solely by CLEAR.

Structure
REQ-031 Shared package xrs_pkg SHALL hold the default XLEN/ADDRW/NRD constants and the FSM state enum (CLEAR, RUN).
REQ-032 The block SHALL instantiate one sub-module xrs_bank per read port: one write port, one synchronous read port, XLEN x 2**ADDRW, inferable as iCE40 block RAM.
REQ-033 Bypass, zero substitution, hold registers, and the FSM SHALL reside in xrs_gen; xrs_bank SHALL contain no control logic.

Verification
REQ-034 Release reset, count cycles -> ready_o rises exactly 32 edges after release (ADDRW=5); a read of r7 returns 0.
REQ-035 Write r5=0xDEADBEEF_CAFEF00D, then read r5 on ports 0 and 1 next cycle -> both return the value one cycle later.
REQ-036 Same edge: write r9=0x1234 and read r9 on port 0 -> BYPASS=1 returns 0x1234; BYPASS=0 returns the prior value.
REQ-037 Write r0=0xFFFF, then read r0 with ra_i switched to r3 the following cycle -> r0 result is 0; r3 result appears one cycle later unaffected.
REQ-038 Hold rre_i[1]=0 while changing ra_i -> rdat_o[1] is unchanged for all cycles.
REQ-039 Assert rst_ni at clear counter 17, then release -> ready_o stays 0 for 32 more cycles; writes issued during that interval are lost (read back 0).

Source files
------------

// File: rtl/xrs_pkg.sv
// Shared constants and FSM state type for the xrs register-file generator.
// Default widths and the CLEAR/RUN state enum live here so bank and top agree.
package xrs_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int ADDRW_DEF = 5;
  localparam int NRD_DEF   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } xrs_state_e;

endpackage

// File: rtl/xrs_bank.sv
// One register-file bank: a single write port and one registered read port.
// Read-before-write on an address collision returns the old contents.
module xrs_bank
  import xrs_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int ADDRW = ADDRW_DEF
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ADDRW-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic             re_i,
  input  logic [ADDRW-1:0] raddr_i,
  output logic [XLEN-1:0]  rdata_o
);

  logic [XLEN-1:0] mem [2**ADDRW];

  // No reset on storage or the read register so the bank maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/xrs_gen.sv
// Multi-read-port register file built from replicated banks, with a clear
// sequencer after reset, optional r0 hardwiring and write-to-read bypass.
module xrs_gen
  import xrs_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ADDRW   = ADDRW_DEF,
  parameter int NRD     = NRD_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDRW-1:0]      rd_i,
  input  logic [XLEN-1:0]       rdat_i,
  input  logic                  rwe_i,
  input  logic [NRD*ADDRW-1:0]  ra_i,
  input  logic [NRD-1:0]        rre_i,
  output logic [NRD*XLEN-1:0]   rdat_o,
  output logic                  ready_o,
  output xrs_state_e            state_o
);

  // Handshake: there is no backpressure. A write is taken on any rising edge
  // where rwe_i=1 and ready_o=1; a read on port k is taken on any edge where
  // rre_i[k]=1 and its data is valid on rdat_o[k] from just after that edge.

  localparam logic [ADDRW-1:0] CNT_MAX = '1;

  xrs_state_e       state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == CNT_MAX) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  assign ready_o = (state_q == RUN);
  assign state_o = state_q;

  logic             wr_user;
  logic             bank_we;
  logic [ADDRW-1:0] bank_waddr;
  logic [XLEN-1:0]  bank_wdata;

  // Gating with rst_ni keeps any write from landing while reset is held.
  assign wr_user    = rwe_i && ready_o && !(ZERO_R0 && (rd_i == '0));
  assign bank_we    = rst_ni && ((state_q == CLEAR) || wr_user);
  assign bank_waddr = (state_q == CLEAR) ? cnt_q : rd_i;
  assign bank_wdata = (state_q == CLEAR) ? '0 : rdat_i;

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [ADDRW-1:0] ra;
    logic [ADDRW-1:0] ra_q;
    logic [XLEN-1:0]  bank_q;
    logic [XLEN-1:0]  byp_q;
    logic             clr_q;
    logic             byp_sel_q;

    assign ra = ra_i[k*ADDRW +: ADDRW];

    xrs_bank #(
      .XLEN  (XLEN),
      .ADDRW (ADDRW)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (bank_we),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .re_i    (rre_i[k]),
      .raddr_i (ra),
      .rdata_o (bank_q)
    );

    // Side registers steer the bank output; clr_q resets high so the port
    // reads zero the moment reset asserts, independent of bank contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ra_q      <= '0;
        clr_q     <= 1'b1;
        byp_sel_q <= 1'b0;
        byp_q     <= '0;
      end else if (rre_i[k]) begin
        ra_q      <= ra;
        clr_q     <= !ready_o;
        byp_sel_q <= BYPASS && wr_user && (rd_i == ra);
        byp_q     <= rdat_i;
      end
    end

    assign rdat_o[k*XLEN +: XLEN] =
      (clr_q || (ZERO_R0 && (ra_q == '0))) ? '0 :
      byp_sel_q                             ? byp_q : bank_q;
  end

endmodule

// File: tb/tb_xrs_gen.sv
// Self-checking bench for xrs_gen: behavioural register-file model compared
// every cycle, plus directed literal checks and randomized traffic.
module tb_xrs_gen;
  import xrs_pkg::*;

  localparam int XLEN    = 64;
  localparam int ADDRW   = 5;
  localparam int NRD     = 2;
  localparam int DEPTH   = 32;
  localparam bit ZERO_R0 = 1'b1;
  localparam bit BYPASS  = 1'b1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [ADDRW-1:0]     rd;
  logic [XLEN-1:0]      wdat;
  logic                 rwe;
  logic [NRD*ADDRW-1:0] ra;
  logic [NRD-1:0]       rre;
  logic [NRD*XLEN-1:0]  rdat_o;
  logic                 ready_o;
  xrs_state_e           state_o;

  xrs_gen #(
    .XLEN(XLEN), .ADDRW(ADDRW), .NRD(NRD), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .rd_i    (rd),
    .rdat_i  (wdat),
    .rwe_i   (rwe),
    .ra_i    (ra),
    .rre_i   (rre),
    .rdat_o  (rdat_o),
    .ready_o (ready_o),
    .state_o (state_o)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_clr counts edges since reset release; the first DEPTH edges are clearing.
  logic [XLEN-1:0] m_mem  [DEPTH];
  logic [XLEN-1:0] m_rdat [NRD];
  int              m_clr;
  int              m_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clr <= 0;
      for (int k = 0; k < NRD; k++) m_rdat[k] <= '0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        if (rre[k]) begin
          m_a = int'(ra[k*ADDRW +: ADDRW]);
          if (m_clr < DEPTH || (ZERO_R0 && m_a == 0))
            m_rdat[k] <= '0;
          else if (BYPASS && rwe && int'(rd) == m_a)
            m_rdat[k] <= wdat;
          else
            m_rdat[k] <= m_mem[m_a];
        end
      end
      if (m_clr < DEPTH) begin
        m_mem[m_clr] <= '0;
        m_clr        <= m_clr + 1;
      end else if (rwe && !(ZERO_R0 && rd == '0)) begin
        m_mem[rd] <= wdat;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", XLEN'(ready_o), XLEN'(m_clr >= DEPTH));
      check("state", XLEN'(state_o), XLEN'((m_clr >= DEPTH) ? RUN : CLEAR));
      for (int k = 0; k < NRD; k++)
        check($sformatf("rdat%0d", k), rdat_o[k*XLEN +: XLEN], m_rdat[k]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    rwe = 1'b0; rd = '0; wdat = '0; rre = '0;
  endtask

  function automatic logic [XLEN-1:0] port(input int k);
    return rdat_o[k*XLEN +: XLEN];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int edges;
    rst_n = 1'b0;
    ra    = '0;
    idle();
    #1;
    check("rst_rdat0", port(0), '0);
    check("rst_rdat1", port(1), '0);
    check("rst_ready", XLEN'(ready_o), '0);
    chk_en = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;

    // Clear length, and a read issued during clearing returns zero.
    ra[0 +: ADDRW] = 5'd7;
    rre = 2'b01;
    edges = 0;
    while (!ready_o && edges < 100) begin
      cyc();
      edges++;
      if (edges == 1) check("clr_read_r7", port(0), '0);
    end
    check("ready_edges", XLEN'(edges), 64'd32);
    cyc();
    check("run_read_r7", port(0), '0);

    // Write r5 then read it on both ports.
    rwe = 1'b1; rd = 5'd5; wdat = 64'hDEADBEEF_CAFEF00D; rre = '0;
    cyc();
    rwe = 1'b0; ra = {5'd5, 5'd5}; rre = 2'b11;
    cyc();
    check("r5_port0", port(0), 64'hDEADBEEF_CAFEF00D);
    check("r5_port1", port(1), 64'hDEADBEEF_CAFEF00D);

    // Same-edge write and read of r9 forwards the new data.
    rwe = 1'b1; rd = 5'd9; wdat = 64'h1234; ra[0 +: ADDRW] = 5'd9; rre = 2'b01;
    cyc();
    check("bypass_r9", port(0), 64'h1234);
    rwe = 1'b0;
    cyc();
    check("after_r9", port(0), 64'h1234);

    // r0 writes are discarded; the following r3 read is unaffected.
    rwe = 1'b1; rd = 5'd3; wdat = 64'hABCD; rre = '0;
    cyc();
    rd = 5'd0; wdat = 64'hFFFF;
    cyc();
    rwe = 1'b0; ra[0 +: ADDRW] = 5'd0; rre = 2'b01;
    cyc();
    ra[0 +: ADDRW] = 5'd3;
    check("r0_zero", port(0), '0);
    cyc();
    check("r3_after_r0", port(0), 64'hABCD);

    // Port 1 holds while its enable is low.
    exp_q.push_back(64'hDEADBEEF_CAFEF00D);
    rre = 2'b01;
    for (int i = 0; i < 20; i++) begin
      ra = ADDRW*NRD'($urandom_range(0, 1023));
      cyc();
      check("hold_port1", port(1), exp_q[0]);
    end
    void'(exp_q.pop_front());

    // Reset at clear counter 17; writes during the re-clear are lost.
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (17) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("midclr_rdat0", port(0), '0);
    check("midclr_rdat1", port(1), '0);
    check("midclr_ready", XLEN'(ready_o), '0);
    cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      rwe = 1'b1; rd = ADDRW'(10 + (i % 8)); wdat = {$urandom(), $urandom()};
      cyc();
      check("reclr_ready", XLEN'(ready_o), XLEN'(i == DEPTH));
    end
    idle();
    ra = {5'd11, 5'd10}; rre = 2'b11;
    cyc();
    check("lost_r10", port(0), '0);
    check("lost_r11", port(1), '0);

    // Randomized traffic with one mid-run reset pulse.
    for (int i = 0; i < 3000; i++) begin
      rre = NRD'($urandom_range(0, 3));
      ra  = (NRD*ADDRW)'($urandom_range(0, 1023));
      rwe = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 3) == 0) ? ra[0 +: ADDRW] : ADDRW'($urandom_range(0, 31));
      wdat = {$urandom(), $urandom()};
      if (i == 1500) begin
        #3 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
